data_mem_stage: RTL and testbench
=================================

# data_mem_stage

Memory-stage data memory with parameterised access latency, placed directly downstream of the pipelined RISC-V datapath (integer ALU and floating-point unit (FPAU)). It consumes the datapath's M-stage read/write strobes, address and store data. It returns load data for capture by the W-stage register. It drives the datapath's pipeline `stall` input, holding all stages while an access is in flight.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: stall cycles per access; allowed range 1..15.
- `ADDR_W`, log2(`DEPTH_WORDS`): derived word-index width; not user-set.

- `clk`  in  1  the single clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  M-stage load strobe.
- `mem_write`  in  1  M-stage store strobe.
- `addr`  in  32  byte address (ALU result from the M stage).
- `write_data`  in  32  store data from the M stage.
- `read_data`  out  32  registered load data; valid in the DONE cycle and held until the next load completes.
- `stall`  out  1  1 = freeze the pipeline this cycle.
- `misaligned`  out  1  one-cycle pulse in DONE when `addr[1:0]` ≠ 0.
- `busy`  out  1  1 when state ≠ IDLE; used for debug and the bench.

## Operation
- `req = mem_read | mem_write`.
- Word index = `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- States: IDLE, BUSY, DONE; 4-bit down-counter `cnt`.
- IDLE:
  - `req`=0: remain in IDLE.
  - `req`=1: load `cnt` = LATENCY−1; go to BUSY if LATENCY>1, else go to DONE and perform the access on this edge.
- BUSY:
  - Decrement `cnt`.
  - When `cnt` = 1, perform the access on this edge and go to DONE.
  - If `req` drops (flush), go to IDLE with no write and no `read_data` update.
- Access on the performing edge:
  - Store: writes `write_data` to the word.
  - Load: latches the word's pre-write contents into `read_data`.
  - Both strobes set: perform both; `read_data` receives the old value.
- DONE: `stall`=0, `misaligned` is valid; the next edge always goes to IDLE. This lets the pipeline advance exactly once per access.
- `stall = req & (state ≠ DONE)`. This is combinational so the request cycle itself is frozen.
- Misaligned accesses still complete on the truncated word index; sub-word stores are not supported.

## Timing
- Reset state: state=IDLE, `cnt`=0, `read_data`=0, `stall`=0 (no req), `misaligned`=0, `busy`=0. The RAM array is not cleared.
- Reset asserted mid-access: return to IDLE immediately; a pending store is discarded.
- Per access: exactly LATENCY cycles with `stall`=1, then one DONE cycle with `stall`=0. Total occupancy is LATENCY+1 cycles.
- Back-to-back accesses: the cycle after DONE is IDLE and can accept a new `req` the same cycle. There is no idle bubble beyond DONE.
- A cycle with no request never stalls.
- `read_data` changes only on a load's performing edge.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, BUSY, DONE}.
  - constant `DMEM_CNT_W` = 4.
  - function `clog2`.
- Sub-module `dmem_ram_sp`: single-port synchronous RAM (we, addr, wdata, rdata), read-before-write, no reset. Instantiated once.
- `data_mem_stage` holds the FSM, counter, `read_data` register and `misaligned` logic.

## Test plan
- Reset then idle, LATENCY=2: no strobes for 10 cycles -> `stall`=0, `busy`=0, `read_data`=0 throughout.
- Store then load:
  - Store 0xDEADBEEF to 0x10 -> `stall` high for 2 cycles, then DONE.
  - Immediate load from 0x10 -> `stall` 2 cycles, `read_data`=0xDEADBEEF in DONE.
- LATENCY=1, back-to-back: loads from 0x0, 0x4, 0x8 (preloaded 1, 2, 3) -> stall pattern 1,0,1,0,1,0; `read_data` 1, 2, 3 in successive DONE cycles.
- Wrap and misalignment, DEPTH_WORDS=256:
  - Store 0x55 to 0x400 -> readable at 0x0.
  - Load at 0x13 -> returns the word at 0x10 with `misaligned`=1 for one cycle.
- Simultaneous strobes: word 0x20 = 0x11; mem_read=mem_write=1, write_data=0x22 -> `read_data`=0x11, then a later load returns 0x22.
- Abort and reset:
  - `req` drops in BUSY during a store of 0x99 to 0x30 -> IDLE; later load returns the old value.
  - `reset` asserted mid-BUSY -> `stall`, `busy` and `read_data` go to 0 asynchronously.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the memory-stage data memory.
//   dmem_state_t : access FSM state (IDLE, BUSY, DONE)
//   DMEM_CNT_W   : width of the latency down-counter
//   clog2        : ceiling log2, used to size the word index
package dmem_pkg;

  localparam int DMEM_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram_sp.sv
// dmem_ram_sp: single-port word RAM, synchronous write, no reset.
//   clk   : write clock
//   we    : write enable for this edge
//   addr  : word index
//   wdata : word to store
//   rdata : current contents of addr
// The read port is combinational, so the value seen before an edge is the
// pre-write contents (read-before-write) and the owner can capture it on the
// same edge the write happens.
module dmem_ram_sp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: M-stage data memory with a fixed multi-cycle access latency.
//   clk, reset  : clock, asynchronous active-high reset
//   mem_read    : load strobe from the M stage
//   mem_write   : store strobe from the M stage
//   addr        : byte address; only addr[ADDR_W+1:2] selects the word
//   write_data  : store data
//   read_data   : registered load result, updated only when a load completes
//   stall       : freezes the pipeline while an access is outstanding
//   misaligned  : one-cycle flag in DONE when addr[1:0] != 0
//   busy        : FSM is not idle
// Each access stalls for LATENCY cycles and then spends one DONE cycle with
// stall low so the pipeline advances exactly once per access.
module data_mem_stage
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        busy
);

  localparam int ADDR_W = clog2(DEPTH_WORDS);

  logic                  req;
  logic [ADDR_W-1:0]     word_idx;
  logic                  access;
  logic [31:0]           ram_rdata;

  dmem_state_t           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  misaligned_q, misaligned_d;

  // Upper address bits are deliberately ignored (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req      = mem_read | mem_write;
  assign word_idx = addr[ADDR_W+1:2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    access       = 1'b0;
    read_data_d  = read_data_q;
    misaligned_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = DMEM_CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            access  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // Flush: request withdrawn, abandon without touching memory.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DMEM_CNT_W'(1)) begin
            state_d = DONE;
            access  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Performing edge: load captures the pre-write word, flag is set for DONE.
    if (access) begin
      if (mem_read) read_data_d = ram_rdata;
      misaligned_d = (addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  dmem_ram_sp #(
    .DEPTH (DEPTH_WORDS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (access & mem_write),
    .addr  (word_idx),
    .wdata (write_data),
    .rdata (ram_rdata)
  );

  // Combinational so the request cycle itself is frozen; held low during
  // reset so the pipeline is never frozen by a discarded access.
  assign stall      = req & (state_q != DONE) & ~reset;
  assign read_data  = read_data_q;
  assign misaligned = misaligned_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;     // 0: LATENCY=2 instance, 1: LATENCY=1 instance
  logic        mr = 1'b0, mw = 1'b0;
  logic [31:0] addr = '0, wdata = '0;

  logic        mr2, mw2, mr1, mw1;
  logic [31:0] rd2, rd1;
  logic        st2, st1, mis2, mis1, bz2, bz1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  assign mr2 = mr & ~sel;
  assign mw2 = mw & ~sel;
  assign mr1 = mr & sel;
  assign mw1 = mw & sel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_stage #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .mem_read(mr2), .mem_write(mw2), .addr(addr),
    .write_data(wdata), .read_data(rd2), .stall(st2), .misaligned(mis2), .busy(bz2)
  );

  data_mem_stage #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(mr1), .mem_write(mw1), .addr(addr),
    .write_data(wdata), .read_data(rd1), .stall(st1), .misaligned(mis1), .busy(bz1)
  );

  wire        cur_stall = sel ? st1 : st2;
  wire [31:0] cur_rd    = sel ? rd1 : rd2;
  wire        cur_mis   = sel ? mis1 : mis2;

  // Drives one access starting in the next cycle and returns what was seen in
  // its DONE cycle. Strobes stay asserted after DONE so a following call is
  // back-to-back; call idle() to drop them.
  task automatic do_access(input logic s, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int nstall, output logic [31:0] rdat,
                           output logic mis);
    bit got;
    @(negedge clk);
    sel = s; mr = rd; mw = wr; addr = a; wdata = wd;
    nstall = 0; got = 0; rdat = 'x; mis = 1'bx;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (cur_stall) nstall++;
      else begin
        got = 1; rdat = cur_rd; mis = cur_mis;
      end
      if (!got) @(negedge clk);
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL access_timeout addr=%h: stall never dropped, required DONE within 40 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mr = 1'b0; mw = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({st2, bz2, mis2, rd2, st1, bz1, mis1, rd1} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%b bz=%b mis=%b rd=%h / st=%b bz=%b mis=%b rd=%h, required all 0",
               st2, bz2, mis2, rd2, st1, bz1, mis1, rd1);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({st2, bz2, rd2, st1, bz1, rd1} !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: st=%b bz=%b rd=%h / st=%b bz=%b rd=%h, required 0",
                 i, st2, bz2, rd2, st1, bz1, rd1);
      end
    end
  endtask

  task automatic test_store_load;
    int n; logic [31:0] r, e; logic m;
    do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, n, r, m);
    n_cmp++;
    if (n !== 2 || r !== 32'h0) begin
      n_fail++;
      $display("FAIL store_0x10: stalls=%0d rd=%h, required stalls=2 rd=00000000", n, r);
    end
    exp_q.push_back(32'hDEADBEEF);
    do_access(0, 1, 0, 32'h10, 32'h0, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (n !== 2 || r !== e || m !== 1'b0) begin
      n_fail++;
      $display("FAIL load_0x10: stalls=%0d rd=%h mis=%b, required stalls=2 rd=%h mis=0", n, r, m, e);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int n, c0; logic [31:0] r, e; logic m;
    logic [5:0] pat;
    for (int i = 0; i < 3; i++) begin
      do_access(1, 0, 1, 32'(i * 4), 32'(i + 1), n, r, m);
      n_cmp++;
      if (n !== 1) begin
        n_fail++;
        $display("FAIL lat1_store%0d: stalls=%0d, required 1", i, n);
      end
    end
    idle(2);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'(i + 1));
      if (i == 0) c0 = cyc + 1;
      do_access(1, 1, 0, 32'(i * 4), 32'h0, n, r, m);
      pat = {pat[3:0], (n == 1), 1'b0};
      e = exp_q.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_fail++;
        $display("FAIL lat1_load%0d: rd=%h, required %h", i, r, e);
      end
    end
    n_cmp++;
    if (pat !== 6'b101010 || (cyc - c0) !== 5) begin
      n_fail++;
      $display("FAIL lat1_stall_pattern: pattern=%b span=%0d, required 101010 span=5", pat, cyc - c0);
    end
    idle(2);
  endtask

  task automatic test_wrap_misalign;
    int n; logic [31:0] r, e; logic m;
    do_access(0, 0, 1, 32'h400, 32'h55, n, r, m);
    exp_q.push_back(32'h55);
    do_access(0, 1, 0, 32'h0, 32'h0, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e || m !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_0x400: rd=%h mis=%b, required %h mis=0", r, m, e);
    end
    exp_q.push_back(32'hDEADBEEF);
    do_access(0, 1, 0, 32'h13, 32'h0, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e || m !== 1'b1 || n !== 2) begin
      n_fail++;
      $display("FAIL misaligned_0x13: rd=%h mis=%b stalls=%0d, required %h mis=1 stalls=2", r, m, n, e);
    end
    idle(1); #1;
    n_cmp++;
    if (mis2 !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_pulse: mis=%b one cycle after DONE, required 0", mis2);
    end
    idle(1);
  endtask

  task automatic test_both_strobes;
    int n; logic [31:0] r, e; logic m;
    do_access(0, 0, 1, 32'h20, 32'h11, n, r, m);
    exp_q.push_back(32'h11);
    do_access(0, 1, 1, 32'h20, 32'h22, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e || n !== 2) begin
      n_fail++;
      $display("FAIL rw_same_cycle: rd=%h stalls=%0d, required %h stalls=2", r, n, e);
    end
    exp_q.push_back(32'h22);
    do_access(0, 1, 0, 32'h20, 32'h0, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL rw_followup_load: rd=%h, required %h", r, e);
    end
    idle(2);
  endtask

  task automatic test_abort;
    int n; logic [31:0] r, e; logic m;
    do_access(0, 0, 1, 32'h30, 32'hAAAA0000, n, r, m);
    idle(2);
    @(negedge clk);
    sel = 0; mw = 1; mr = 0; addr = 32'h30; wdata = 32'h99;
    @(negedge clk); #1;
    n_cmp++;
    if (bz2 !== 1'b1 || st2 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_busy: bz=%b st=%b, required bz=1 st=1", bz2, st2);
    end
    mw = 0; #1;
    n_cmp++;
    if (st2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stall_drop: st=%b, required 0", st2);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bz2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_to_idle: bz=%b, required 0", bz2);
    end
    exp_q.push_back(32'hAAAA0000);
    do_access(0, 1, 0, 32'h30, 32'h0, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL abort_no_write: rd=%h, required %h", r, e);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int n; logic [31:0] r, e; logic m;
    do_access(0, 0, 1, 32'h40, 32'h66, n, r, m);
    do_access(0, 1, 0, 32'h40, 32'h0, n, r, m);
    idle(2);
    @(negedge clk);
    sel = 0; mw = 1; mr = 0; addr = 32'h40; wdata = 32'h77;
    @(negedge clk); #1;
    reset = 1'b1; #1;
    n_cmp++;
    if (st2 !== 1'b0 || bz2 !== 1'b0 || rd2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: st=%b bz=%b rd=%h, required 0 0 00000000", st2, bz2, rd2);
    end
    @(negedge clk);
    reset = 1'b0; mw = 0;
    idle(2);
    exp_q.push_back(32'h66);
    do_access(0, 1, 0, 32'h40, 32'h0, n, r, m);
    e = exp_q.pop_front();
    n_cmp++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL reset_discard_store: rd=%h, required %h", r, e);
    end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_back_to_back;
    test_wrap_misalign;
    test_both_strobes;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
